// File: rtl/decade_scan_counter.sv
// decade_scan_counter: prescaled BCD up/down counter with load/error flag and a 4-phase scan select.
// Define DECADE_SCAN_BLANK_EN to blank E for one cycle at every scan-select change.
module decade_scan_counter #(
    parameter int TICK_DIV = 4,
    parameter int SCAN_DIV = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       tc,
    output logic       err,
    output logic [1:0] s,
    output logic       e
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    logic [PW-1:0] pre;
    logic [SW-1:0] sdiv;
    logic          tick;
    logic          wrap_s;
    logic [3:0]    q_step;
    assign tick   = en && pre == PW'(TICK_DIV - 1);
    assign wrap_s = sdiv == SW'(SCAN_DIV - 1);
    assign q_step = up ? (q == 4'd9 ? 4'd0 : q + 4'd1) : (q == 4'd0 ? 4'd9 : q - 4'd1);
    // An illegal load freezes count and prescaler for that cycle and only raises err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            tc   <= 1'b0;
            err  <= 1'b0;
            pre  <= '0;
            sdiv <= '0;
            s    <= '0;
            e    <= 1'b0;
        end else begin
            tc  <= 1'b0;
            err <= 1'b0;
            if (ld) begin
                if (d <= 4'd9) begin
                    q   <= d;
                    pre <= '0;
                end else err <= 1'b1;
            end else if (tick) begin
                q   <= q_step;
                pre <= '0;
                tc  <= up ? (q == 4'd9) : (q == 4'd0);
            end else if (en) pre <= pre + 1'b1;
            sdiv <= wrap_s ? '0 : sdiv + 1'b1;
            if (wrap_s) s <= s + 1'b1;
`ifdef DECADE_SCAN_BLANK_EN
            e <= !wrap_s;
`else
            e <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_decade_scan_counter.sv
// tb_decade_scan_counter: randomized + directed scoreboard bench against a cycle-count reference model.
module tb_decade_scan_counter;
    localparam int TD = 4;
    localparam int SD = 3;
`ifdef DECADE_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b1, ld = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q;
    logic       tc, err, e;
    logic [1:0] s;
    int tests = 0, fails = 0;
    logic [8:0] exp_q[$];
    int q_m = 0, pre_m = 0, cyc = 0;
    bit tc_m = 0, err_m = 0;

    decade_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .d(d),
        .q(q), .tc(tc), .err(err), .s(s), .e(e)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] expected();
        logic [1:0] s_m;
        logic e_m;
        s_m = 2'((cyc / SD) % 4);
        e_m = cyc > 0 && (!BLANK || cyc % SD != 0);
        return {4'(q_m), tc_m, err_m, s_m, e_m};
    endfunction

    // Reference: one clock edge of the spec's rules in plain integer arithmetic
    task automatic advance();
        tc_m = 0;
        err_m = 0;
        if (ld) begin
            if (d <= 9) begin
                q_m = d;
                pre_m = 0;
            end else err_m = 1;
        end else if (en) begin
            if (pre_m == TD - 1) begin
                pre_m = 0;
                q_m = up ? (q_m + 1) % 10 : (q_m + 9) % 10;
                tc_m = up ? q_m == 0 : q_m == 9;
            end else pre_m++;
        end
        cyc++;
        exp_q.push_back(expected());
    endtask

    task automatic step(input logic en_i, input logic up_i, input logic ld_i, input logic [3:0] d_i);
        @(negedge clk);
        en = en_i;
        up = up_i;
        ld = ld_i;
        d = d_i;
        advance();
    endtask

    task automatic run(input int n, input logic en_i, input logic up_i);
        for (int i = 0; i < n; i++) step(en_i, up_i, 1'b0, 4'd0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({q, tc, err, s, e} !== 9'd0) begin
            fails++;
            $display("FAIL async_reset: got q=%0d tc=%0b err=%0b s=%0d e=%0b, want all zero", q, tc, err, s, e);
        end
        q_m = 0; pre_m = 0; cyc = 0; tc_m = 0; err_m = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back(9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        up = 1'b1;
        ld = 1'b0;
        advance();
    endtask

    initial begin : monitor
        logic [8:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                tests++;
                if ({q, tc, err, s, e} !== w) begin
                    fails++;
                    $display("FAIL cycle@%0t: got q=%0d tc=%0b err=%0b s=%0d e=%0b, want q=%0d tc=%0b err=%0b s=%0d e=%0b",
                             $time, q, tc, err, s, e, w[8:5], w[4], w[3], w[2:1], w[0]);
                end
            end
        end
    end

    initial begin
        #1;
        tests++;
        if ({q, tc, err, s, e} !== 9'd0) begin
            fails++;
            $display("FAIL reset_state: got q=%0d tc=%0b err=%0b s=%0d e=%0b, want all zero", q, tc, err, s, e);
        end
        @(negedge clk);
        exp_q.push_back(9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        advance();
        run(40, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 4'd7);
        run(44, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'd3);
        run(2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'd12);
        run(6, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'd5);
        run(2, 1'b1, 1'b1);
        run(10, 1'b0, 1'b1);
        run(6, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'd8);
        run(1, 1'b1, 1'b1);
        async_reset();
        run(12, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 11) == 0, 4'($urandom));
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
